loop_progress_monitor: RTL and testbench

- Downstream checker for the bounded x/y/size loop counter.
- Samples the counter's registered outputs x, y, size and its selector input every cycle.
- Verifies reset values, single-step progress, the x == y+1 invariant, size stability and the terminal condition (x > size implies y == size).
- Reports done/error status plus progress statistics to the test harness or a system status register.

---
 rtl/loop_progress_monitor.sv | 86 ++++++++
 tb/tb_loop_progress_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/loop_progress_monitor.sv
// loop_progress_monitor: checks a bounded x/y/size loop counter for reset values, stepping, invariant and termination.
// Optional stall watchdog (error code 6) is enabled by defining LOOP_MONITOR_TIMEOUT_EN.
module loop_progress_monitor #(
  parameter int W           = 8,
  parameter int INIT_X      = 1,
  parameter int INIT_Y      = 0,
  parameter int INIT_SIZE   = 230,
  parameter int CW          = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          selector,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  size,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [CW-1:0] step_count,
  output logic [CW-1:0] stall_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;
  if (STALL_LIMIT < 1) $error("STALL_LIMIT must be positive");
  state_t        r_state, w_next;
  logic [W-1:0]  r_px, r_py, r_ps;
  logic          r_psel;
  logic [2:0]    r_code, w_code, w_init_code, w_run_code, w_done_code;
  logic [CW-1:0] r_steps, r_stalls;
  logic          w_adv, w_step_bad, w_size_bad, w_inv_bad, w_term_bad, w_to, w_xy_chg;
  assign w_adv      = r_psel && (r_px <= r_ps);
  assign w_xy_chg   = (x != r_px) || (y != r_py);
  assign w_step_bad = w_adv ? (x != W'(r_px + 1'b1) || y != W'(r_py + 1'b1)) : w_xy_chg;
  assign w_size_bad = size != r_ps;
  assign w_inv_bad  = x != W'(y + 1'b1);
  assign w_term_bad = (x > size) && (y != size);
`ifdef LOOP_MONITOR_TIMEOUT_EN
  localparam int WDW = $clog2(STALL_LIMIT + 1);
  logic [WDW-1:0] r_wd;
  // r_wd holds the stalls already seen, so the STALL_LIMIT-th stall trips here
  assign w_to = !w_adv && (r_wd == WDW'(STALL_LIMIT - 1));
  always_ff @(posedge clk) begin
    if (rst) r_wd <= '0;
    else if (r_state == RUN && w_code == 3'd0) r_wd <= w_adv ? '0 : r_wd + 1'b1;
  end
`else
  assign w_to = 1'b0;
`endif
  assign w_init_code = (x == W'(INIT_X) && y == W'(INIT_Y) && size == W'(INIT_SIZE)) ? 3'd0 : 3'd1;
  assign w_run_code  = w_step_bad ? 3'd2 : w_size_bad ? 3'd3 : w_inv_bad ? 3'd4 :
                       w_term_bad ? 3'd5 : w_to ? 3'd6 : 3'd0;
  assign w_done_code = w_xy_chg ? 3'd2 : w_size_bad ? 3'd3 : 3'd0;
  always_comb begin
    w_code = r_state == IDLE ? w_init_code : r_state == RUN ? w_run_code :
             r_state == DONE ? w_done_code : 3'd0;
    w_next = (r_state == ERROR || w_code != 3'd0) ? ERROR :
             r_state == IDLE ? RUN :
             (r_state == RUN && x > size) ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_px     <= '0;
      r_py     <= '0;
      r_ps     <= '0;
      r_psel   <= 1'b0;
      r_code   <= 3'd0;
      r_steps  <= '0;
      r_stalls <= '0;
    end else begin
      r_state <= w_next;
      r_px    <= x;
      r_py    <= y;
      r_ps    <= size;
      r_psel  <= selector;
      if (w_code != 3'd0) r_code <= w_code;
      if (r_state == RUN && w_code == 3'd0 && w_adv && !(&r_steps)) r_steps <= r_steps + 1'b1;
      if (r_state == RUN && w_code == 3'd0 && !w_adv && !(&r_stalls)) r_stalls <= r_stalls + 1'b1;
    end
  end
  assign done        = r_state == DONE;
  assign err         = r_state == ERROR;
  assign err_code    = r_code;
  assign step_count  = r_steps;
  assign stall_count = r_stalls;
endmodule

// File: tb/tb_loop_progress_monitor.sv
// tb_loop_progress_monitor: directed checks of the loop monitor driven by a behavioural counter.
module tb_loop_progress_monitor;
  logic        clk = 1'b0, rst = 1'b1, selector = 1'b0;
  logic [7:0]  x, y, size;
  logic        done, err;
  logic [2:0]  err_code;
  logic [15:0] step_count, stall_count;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  loop_progress_monitor #(.STALL_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .selector(selector), .x(x), .y(y), .size(size),
    .done(done), .err(err), .err_code(err_code),
    .step_count(step_count), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock of the counter being monitored; outputs are then sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      x = 8'd1; y = 8'd0; size = 8'd230;
    end else if (selector && x <= size) begin
      x = x + 8'd1; y = y + 8'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_step"}, step_count, 0);
    chk({tag, "_stall"}, stall_count, 0);
  endtask

  initial begin
    do_reset();
    chk_clear("rst");

    selector = 1'b1;
    repeat (230) tick();
    chk("run1_pre_done", done, 0);
    chk("run1_pre_step", step_count, 229);
    tick();
    chk("run1_done", done, 1);
    chk("run1_step", step_count, 230);
    chk("run1_stall", stall_count, 0);
    chk("run1_err", err, 0);
    repeat (4) tick();
    chk("hold_done", done, 1);
    chk("hold_step", step_count, 230);
    y = 8'd99;
    tick();
    chk("donechg_err", err, 1);
    chk("donechg_done", done, 0);
    chk("donechg_code", err_code, 2);

    do_reset();
    chk_clear("rst2");
    for (int i = 0; i < 459; i++) begin
      selector = (i % 2 == 0);
      tick();
    end
    chk("alt_pre_done", done, 0);
    selector = 1'b0;
    tick();
    chk("alt_done", done, 1);
    chk("alt_step", step_count, 230);
    chk("alt_stall", stall_count, 229);
    chk("alt_err", err, 0);

    do_reset();
    selector = 1'b1;
    repeat (11) tick();
    chk("jump_pre_step", step_count, 10);
    chk("jump_pre_err", err, 0);
    x = 8'd13; y = 8'd11;
    tick();
    chk("jump_err", err, 1);
    chk("jump_code", err_code, 2);
    chk("jump_done", done, 0);
    tick();
    chk("jump_frozen", step_count, 10);
    chk("jump_code_held", err_code, 2);

    do_reset();
    selector = 1'b1;
    repeat (5) tick();
    size = 8'd100;
    tick();
    chk("size_err", err, 1);
    chk("size_code", err_code, 3);
    chk("size_step", step_count, 4);

    do_reset();
    x = 8'd5;
    tick();
    chk("init_err", err, 1);
    chk("init_code", err_code, 1);

    do_reset();
    selector = 1'b1;
    repeat (3) tick();
    selector = 1'b0;
    tick();
    chk("stall_step", step_count, 3);
    chk("stall_zero", stall_count, 0);
    repeat (15) tick();
    chk("stall15_err", err, 0);
    chk("stall15_cnt", stall_count, 15);
    tick();
`ifdef LOOP_MONITOR_TIMEOUT_EN
    chk("to_err", err, 1);
    chk("to_code", err_code, 6);
    chk("to_stall", stall_count, 15);
`else
    chk("nto_err", err, 0);
    chk("nto_stall", stall_count, 16);
    repeat (10) tick();
    chk("nto_err2", err, 0);
    chk("nto_stall2", stall_count, 26);
`endif

    do_reset();
    selector = 1'b1;
    repeat (49) tick();
    chk("mid_x50_step", step_count, 48);
    rst = 1'b1;
    tick();
    chk_clear("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_idle_err", err, 0);
    repeat (230) tick();
    chk("midrst_done", done, 1);
    chk("midrst_step", step_count, 230);
    chk("midrst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
